// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-controlled programmable clock divider (start/stop, continuous or burst, shadowed reconfig).
// Latency: clk_out/tick registered; first rising edge half+1 clk_in cycles after the start edge.
// Backpressure: cfg_ready is 1 in IDLE; while busy it drops until the shadow config is taken at the next wrap.
// Optional feature: define CLK_DIV_CTRL_CNT_EN to add edge_cnt[15:0] (saturating rising-edge count since start).
module clk_div_ctrl #(
  parameter int unsigned CNT_W        = 26,
  parameter int unsigned DEFAULT_HALF = 2499,
  parameter int unsigned MIN_HALF     = 1
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_half,
  input  logic             cfg_burst,
  input  logic [7:0]       cfg_len,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic             done
`ifdef CLK_DIV_CTRL_CNT_EN
  ,
  output logic [15:0]      edge_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  typedef struct packed {
    logic [CNT_W-1:0] half;
    logic             burst;
    logic [7:0]       len;
  } cfg_t;

  localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEFAULT_HALF);
  localparam logic [CNT_W-1:0] MIN_H = CNT_W'(MIN_HALF);
  localparam cfg_t RESET_CFG = {DEF_H, 1'b0, 8'd0};

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             clk_nxt, tick_nxt, done_nxt;
  cfg_t             act, act_nxt;
  cfg_t             sh, sh_nxt;
  logic             sh_vld, sh_vld_nxt;
  logic [7:0]       edges, edges_nxt;

  logic [CNT_W-1:0] half_clamped;
  cfg_t             cfg_in;
  logic             cfg_acc;
  logic             wrap;
  logic             rise;
  logic             to_idle;

  // Incoming config with the half-period clamped to the smallest legal count.
  assign half_clamped = (cfg_half < MIN_H) ? MIN_H : cfg_half;
  assign cfg_in       = {half_clamped, cfg_burst, cfg_len};
  assign cfg_ready    = (state == IDLE) || !sh_vld;
  assign cfg_acc      = cfg_valid && cfg_ready;
  assign wrap         = (cnt == act.half);
  assign rise         = wrap && !clk_out;

  // Next-state, counter, clock-phase and config-bank decisions.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    clk_nxt    = clk_out;
    tick_nxt   = 1'b0;
    done_nxt   = 1'b0;
    act_nxt    = act;
    sh_nxt     = sh;
    sh_vld_nxt = sh_vld;
    edges_nxt  = edges;
    to_idle    = 1'b0;

    case (state)
      IDLE: begin
        // A config accepted alongside start takes effect from the next cycle;
        // the start decision itself looks at the config already held.
        if (cfg_acc) act_nxt = cfg_in;
        if (start && !stop) begin
          if (act.burst && (act.len == 8'd0)) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = RUN;
            cnt_nxt   = '0;
            clk_nxt   = 1'b0;
            edges_nxt = '0;
          end
        end
      end

      RUN: begin
        if (wrap) begin
          cnt_nxt = '0;
          clk_nxt = ~clk_out;
          if (sh_vld) begin
            act_nxt    = sh;
            sh_vld_nxt = 1'b0;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
        if (rise) begin
          tick_nxt  = 1'b1;
          edges_nxt = edges + 8'd1;
          if (act.burst && ((edges + 8'd1) == act.len)) state_nxt = STOPPING;
        end
        // Stop in the low phase ends at once (and suppresses a coincident rise);
        // stop in the high phase waits for the fall unless it falls right now.
        if (stop) begin
          if (!clk_out || wrap) to_idle = 1'b1;
          else                  state_nxt = STOPPING;
        end
      end

      STOPPING: begin
        if (wrap) to_idle = 1'b1;
        else      cnt_nxt = cnt + CNT_W'(1);
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (to_idle) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      clk_nxt   = 1'b0;
      tick_nxt  = 1'b0;
      done_nxt  = 1'b1;
      if (sh_vld) begin
        act_nxt    = sh;
        sh_vld_nxt = 1'b0;
      end
    end

    // While busy, new configs wait in the shadow; if we are leaving for IDLE
    // this cycle there is nothing to synchronise with, so write active directly.
    if (cfg_acc && (state != IDLE)) begin
      if (state_nxt == IDLE) begin
        act_nxt = cfg_in;
      end else begin
        sh_nxt     = cfg_in;
        sh_vld_nxt = 1'b1;
      end
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      act     <= RESET_CFG;
      sh      <= RESET_CFG;
      sh_vld  <= 1'b0;
      edges   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      clk_out <= clk_nxt;
      tick    <= tick_nxt;
      busy    <= (state_nxt != IDLE);
      done    <= done_nxt;
      act     <= act_nxt;
      sh      <= sh_nxt;
      sh_vld  <= sh_vld_nxt;
      edges   <= edges_nxt;
    end
  end

`ifdef CLK_DIV_CTRL_CNT_EN
  logic start_go;
  assign start_go = (state == IDLE) && (state_nxt == RUN);

  // Saturating count of rising edges since the last start.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      edge_cnt <= '0;
    end else if (start_go) begin
      edge_cnt <= '0;
    end else if (tick_nxt && (edge_cnt != 16'hFFFF)) begin
      edge_cnt <= edge_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: default period, stop in high phase, burst,
// shadowed reconfig with backpressure, clamping, start/stop collision, reset in STOPPING.
module tb_clk_div_ctrl;

  logic        clk_in    = 1'b0;
  logic        reset     = 1'b0;
  logic        start     = 1'b0;
  logic        stop      = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_burst = 1'b0;
  logic [25:0] cfg_half  = '0;
  logic [7:0]  cfg_len   = '0;
  logic        cfg_ready, clk_out, tick, busy, done;
`ifdef CLK_DIV_CTRL_CNT_EN
  logic [15:0] edge_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  clk_div_ctrl dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_half  (cfg_half),
    .cfg_burst (cfg_burst),
    .cfg_len   (cfg_len),
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy),
    .done      (done)
`ifdef CLK_DIV_CTRL_CNT_EN
    ,
    .edge_cnt  (edge_cnt)
`endif
  );

  // Advance negedges until the selected output is seen high (0 tick, 1 done, 2 cfg_ready) or lim is hit.
  task automatic wait_for(input int sel, input int lim, output int n);
    logic hit;
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
      hit = (sel == 0) ? tick : (sel == 1) ? done : cfg_ready;
    end while (!hit && n < lim);
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
    repeat (2) @(negedge clk_in);
    reset = 1'b1;
    @(negedge clk_in);
  endtask

  task automatic set_cfg(input logic [25:0] h, input logic b, input logic [7:0] l);
    cfg_half = h; cfg_burst = b; cfg_len = l; cfg_valid = 1'b1;
    @(negedge clk_in);
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk_in);
    checks++; if (clk_out !== 1'b0) begin errors++; $display("FAIL reset_clk_out: got %b expected 0", clk_out); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", tick); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %b expected 1", cfg_ready); end
`ifdef CLK_DIV_CTRL_CNT_EN
    checks++; if (edge_cnt !== 16'd0) begin errors++; $display("FAIL reset_edge_cnt: got %0d expected 0", edge_cnt); end
`endif
    reset = 1'b1;
    @(negedge clk_in);
  endtask

  task automatic test_default_period();
    int n;
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dflt_busy: got %b expected 1", busy); end
    wait_for(0, 3000, n);
    checks++; if (n != 2500) begin errors++; $display("FAIL dflt_first_tick: got %0d cycles expected 2500", n); end
    @(negedge clk_in);
    checks++; if (tick !== 1'b0 || clk_out !== 1'b1) begin errors++; $display("FAIL dflt_tick_width: got tick=%b clk_out=%b expected tick=0 clk_out=1", tick, clk_out); end
    wait_for(0, 6000, n);
    checks++; if (n + 1 != 5000) begin errors++; $display("FAIL dflt_period: got %0d cycles expected 5000", n + 1); end
    do_reset();
  endtask

  task automatic test_stop_high();
    int n, hi, lo;
    set_cfg(26'd3, 1'b0, 8'd0);
    pulse_start();
    wait_for(0, 20, n);
    checks++; if (n != 4) begin errors++; $display("FAIL h3_first_tick: got %0d expected 4", n); end
    hi = 0; while (clk_out && hi < 20) begin hi++; @(negedge clk_in); end
    lo = 0; while (!clk_out && lo < 20) begin lo++; @(negedge clk_in); end
    checks++; if (hi != 4) begin errors++; $display("FAIL h3_high_len: got %0d expected 4", hi); end
    checks++; if (lo != 4) begin errors++; $display("FAIL h3_low_len: got %0d expected 4", lo); end
    // Now at the start of a high phase: request stop.
    stop = 1'b1;
    @(negedge clk_in);
    stop = 1'b0;
    checks++; if (busy !== 1'b1 || clk_out !== 1'b1) begin errors++; $display("FAIL stop_hold_high: got busy=%b clk_out=%b expected 1 1", busy, clk_out); end
    wait_for(1, 20, n);
    checks++; if (n != 3) begin errors++; $display("FAIL stop_done_delay: got %0d expected 3", n); end
    checks++; if (busy !== 1'b0 || clk_out !== 1'b0) begin errors++; $display("FAIL stop_final: got busy=%b clk_out=%b expected 0 0", busy, clk_out); end
    @(negedge clk_in);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL stop_done_width: got %b expected 0", done); end
    do_reset();
  endtask

  task automatic test_burst();
    int ticks, rises, dones, dn;
    logic prev;
    set_cfg(26'd1, 1'b1, 8'd3);
    pulse_start();
    ticks = 0; rises = 0; dones = 0; dn = -1; prev = clk_out;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_in);
      if (tick) ticks++;
      if (clk_out && !prev) rises++;
      prev = clk_out;
      if (done) begin dones++; dn = i; end
    end
    checks++; if (ticks != 3) begin errors++; $display("FAIL burst_ticks: got %0d expected 3", ticks); end
    checks++; if (rises != 3) begin errors++; $display("FAIL burst_rises: got %0d expected 3", rises); end
    checks++; if (dones != 1) begin errors++; $display("FAIL burst_dones: got %0d expected 1", dones); end
    checks++; if (dn != 12) begin errors++; $display("FAIL burst_done_time: got %0d expected 12", dn); end
    checks++; if (clk_out !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL burst_final: got clk_out=%b busy=%b expected 0 0", clk_out, busy); end
`ifdef CLK_DIV_CTRL_CNT_EN
    checks++; if (edge_cnt !== 16'd3) begin errors++; $display("FAIL burst_edge_cnt: got %0d expected 3", edge_cnt); end
`endif
    do_reset();
  endtask

  task automatic test_reconfig();
    int n, hi, lo;
    set_cfg(26'd3, 1'b0, 8'd0);
    pulse_start();
    wait_for(0, 20, n);
    @(negedge clk_in);
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rcfg_ready_idle_run: got %b expected 1", cfg_ready); end
    cfg_half = 26'd7; cfg_valid = 1'b1;
    @(negedge clk_in);
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rcfg_ready_drop: got %b expected 0", cfg_ready); end
    cfg_half = 26'd5;
    wait_for(2, 20, n);
    checks++; if (n != 2) begin errors++; $display("FAIL rcfg_stall: got %0d expected 2", n); end
    lo = (clk_out == 1'b0) ? 1 : 0;
    @(negedge clk_in);
    cfg_valid = 1'b0;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rcfg_second_taken: got %b expected 0", cfg_ready); end
    if (!clk_out) lo++;
    while (!clk_out && lo < 40) begin @(negedge clk_in); if (!clk_out) lo++; end
    checks++; if (lo != 8) begin errors++; $display("FAIL rcfg_low_len: got %0d expected 8", lo); end
    hi = 0; while (clk_out && hi < 40) begin hi++; @(negedge clk_in); end
    checks++; if (hi != 6) begin errors++; $display("FAIL rcfg_high_len: got %0d expected 6", hi); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rcfg_ready_back: got %b expected 1", cfg_ready); end
    do_reset();
  endtask

  task automatic test_clamp_idle();
    int n, hi, act;
    set_cfg(26'd0, 1'b0, 8'd0);
    pulse_start();
    wait_for(0, 20, n);
    checks++; if (n != 2) begin errors++; $display("FAIL clamp_first_tick: got %0d expected 2", n); end
    hi = 0; while (clk_out && hi < 20) begin hi++; @(negedge clk_in); end
    checks++; if (hi != 2) begin errors++; $display("FAIL clamp_high_len: got %0d expected 2", hi); end
    do_reset();
    start = 1'b1; stop = 1'b1;
    @(negedge clk_in);
    start = 1'b0; stop = 1'b0;
    act = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy || clk_out || tick || done) act++;
      @(negedge clk_in);
    end
    checks++; if (act != 0) begin errors++; $display("FAIL start_stop_idle: got %0d active cycles expected 0", act); end
    set_cfg(26'd1, 1'b1, 8'd0);
    pulse_start();
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL len0_done: got done=%b busy=%b expected 1 0", done, busy); end
    act = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      if (busy || clk_out || tick || done) act++;
    end
    checks++; if (act != 0) begin errors++; $display("FAIL len0_quiet: got %0d active cycles expected 0", act); end
    do_reset();
  endtask

  task automatic test_reset_stopping();
    int n, dones;
    set_cfg(26'd3, 1'b0, 8'd0);
    pulse_start();
    wait_for(0, 20, n);
    stop = 1'b1;
    @(negedge clk_in);
    stop = 1'b0;
    checks++; if (busy !== 1'b1 || clk_out !== 1'b1) begin errors++; $display("FAIL rst_stopping_pre: got busy=%b clk_out=%b expected 1 1", busy, clk_out); end
`ifdef CLK_DIV_CTRL_CNT_EN
    checks++; if (edge_cnt !== 16'd1) begin errors++; $display("FAIL rst_edge_cnt_pre: got %0d expected 1", edge_cnt); end
`endif
    reset = 1'b0;
    @(negedge clk_in);
    checks++; if (clk_out !== 1'b0 || busy !== 1'b0 || tick !== 1'b0) begin errors++; $display("FAIL rst_stopping_outs: got clk_out=%b busy=%b tick=%b expected 0 0 0", clk_out, busy, tick); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_stopping_ready: got %b expected 1", cfg_ready); end
`ifdef CLK_DIV_CTRL_CNT_EN
    checks++; if (edge_cnt !== 16'd0) begin errors++; $display("FAIL rst_edge_cnt: got %0d expected 0", edge_cnt); end
`endif
    dones = done ? 1 : 0;
    repeat (2) @(negedge clk_in);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_in);
      if (done) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL rst_no_done: got %0d done pulses expected 0", dones); end
  endtask

  initial begin
    test_reset();
    test_default_period();
    test_stop_high();
    test_burst();
    test_reconfig();
    test_clamp_idle();
    test_reset_stopping();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
